// File: rtl/stack_pointer_unit_if.sv
// Command/memory-access bundle for stack_pointer_unit: the command handshake
// plus the data-memory address, strobes and jump request it produces.
interface stack_pointer_unit_if #(
    parameter int SP_WIDTH = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [SP_WIDTH-1:0] mem_addr;
    logic                mem_we;
    logic                mem_re;
    logic                jump_req;

    modport master (
        output cmd_valid, cmd_op,
        input  cmd_ready, mem_addr, mem_we, mem_re, jump_req
    );

    modport slave (
        input  cmd_valid, cmd_op,
        output cmd_ready, mem_addr, mem_we, mem_re, jump_req
    );
endinterface

// File: rtl/stack_pointer_unit.sv
// Stack pointer unit: two-state IDLE/ACCESS sequencer for PUSH/POP/CALL/RETURN.
// Optional macro SP_BOUNDS_TRAP_EN turns overflow/underflow into trapped no-ops.
module stack_pointer_unit #(
    parameter int                    SP_WIDTH = 8,
    parameter logic [SP_WIDTH-1:0]   SP_INIT  = 8'h3E,
    parameter int                    STEP     = 2,
    parameter int                    DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         err_clr,
    stack_pointer_unit_if.slave          bus,
    output logic [SP_WIDTH-1:0]          sp,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         ovf_err,
    output logic                         unf_err
);
    localparam int DW = $clog2(DEPTH+1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [SP_WIDTH-1:0] addr_q, addr_d;
    logic                trap_q, trap_d;
    logic [SP_WIDTH-1:0] sp_q, sp_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic accept;
    logic push_cmd;
    logic bad_cmd;
    logic strobe_en;

    assign accept   = (state_q == ST_IDLE) && bus.cmd_valid;
    assign push_cmd = ~bus.cmd_op[0];

`ifdef SP_BOUNDS_TRAP_EN
    assign bad_cmd = (push_cmd && full) || (!push_cmd && empty);
`else
    assign bad_cmd = 1'b0;
    wire unused_err_clr = err_clr;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        trap_d  = trap_q;
        sp_d    = sp_q;
        depth_d = depth_q;

        if (flush) begin
            state_d = ST_IDLE;
            trap_d  = 1'b0;
            sp_d    = SP_INIT;
            depth_d = '0;
        end else if (accept) begin
            state_d = ST_ACCESS;
            op_d    = bus.cmd_op;
            addr_d  = push_cmd ? sp_q + SP_WIDTH'(STEP) : sp_q;
            trap_d  = bad_cmd;
        end else if (state_q == ST_ACCESS) begin
            state_d = ST_IDLE;
            trap_d  = 1'b0;
            // Depth saturates so it stays meaningful even when sp wraps untrapped
            if (!trap_q) begin
                if (!op_q[0]) begin
                    sp_d = sp_q + SP_WIDTH'(STEP);
                    if (depth_q != DW'(DEPTH)) depth_d = depth_q + DW'(1);
                end else begin
                    sp_d = sp_q - SP_WIDTH'(STEP);
                    if (depth_q != '0) depth_d = depth_q - DW'(1);
                end
            end
        end
    end

    always_comb begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
`ifdef SP_BOUNDS_TRAP_EN
        ovf_d = err_clr ? 1'b0 : ovf_q;
        unf_d = err_clr ? 1'b0 : unf_q;
        if (!flush && accept && bad_cmd) begin
            if (push_cmd) ovf_d = 1'b1;
            else          unf_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 2'b00;
            addr_q  <= SP_INIT;
            trap_q  <= 1'b0;
            sp_q    <= SP_INIT;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            trap_q  <= trap_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign strobe_en     = (state_q == ST_ACCESS) && !trap_q;
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.mem_addr  = (state_q == ST_ACCESS) ? addr_q : sp_q;
    assign bus.mem_we    = strobe_en && !op_q[0];
    assign bus.mem_re    = strobe_en &&  op_q[0];
    assign bus.jump_req  = strobe_en &&  op_q[1];

    assign sp      = sp_q;
    assign depth   = depth_q;
    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DW'(DEPTH));
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
endmodule
